alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//   Upstream issue stage for the combinational ALU. Buffers (a, b, op) commands in a small
//   FIFO, presents one command at a time on the ALU operand bus, captures the ALU result and
//   flags into a register, and hands them downstream over a valid/ready interface.
//   Turns the purely combinational ALU into a flow-controlled, clocked pipeline stage.
// PARAMETERS
//   BITS   8   operand/result width; must equal the ALU's BITS
//   DEPTH  4   command FIFO entries; power of 2, >= 2
// PORTS
//   i_clk          in   1     single clock, all state updates on posedge
//   i_rst          in   1     reset, synchronous, active-high
//   i_cmd_valid    in   1     command present
//   o_cmd_ready    out  1     FIFO can accept a command (= !full)
//   i_cmd_a        in   BITS  operand A
//   i_cmd_b        in   BITS  operand B
//   i_cmd_op       in   2     ALU opcode (00 sub, 10 shift, others passed through)
//   o_alu_a        out  BITS  registered operand A to ALU i_a
//   o_alu_b        out  BITS  registered operand B to ALU i_b
//   o_alu_op       out  2     registered opcode to ALU i_op
//   i_alu_out      in   BITS  ALU o_out
//   i_alu_carry    in   1     ALU o_carry
//   i_alu_err      in   1     ALU o_ERR
//   i_alu_even     in   1     ALU o_even
//   i_alu_single   in   1     ALU o_single
//   o_res_valid    out  1     result register holds an undelivered result
//   i_res_ready    in   1     downstream accepts result
//   o_res          out  BITS  captured ALU result
//   o_res_flags    out  4     {carry, err, even, single} captured with o_res
//   o_res_op       out  2     opcode that produced o_res
// BEHAVIOUR
//   - Reset: FIFO emptied, FSM -> IDLE; every output 0 except o_cmd_ready=1 (reset has priority
//     over every other event; a reset mid-operation discards queued and in-flight commands).
//   - Push: i_cmd_valid && o_cmd_ready writes FIFO. o_cmd_ready depends only on registered
//     count, never combinationally on a same-cycle pop; full FIFO refuses push even if popping.
//   - Pop only when FIFO non-empty; FIFO order strictly preserved; pointers wrap mod DEPTH.
//   - FSM IDLE: if non-empty, pop head into o_alu_a/b/op -> EXEC; else stay.
//   - FSM EXEC: operands stable on ALU for whole cycle; at cycle end capture i_alu_* and
//     o_alu_op into o_res/o_res_flags/o_res_op, set o_res_valid -> DONE.
//   - FSM DONE: hold o_res*, o_alu_* stable while !i_res_ready. On i_res_ready: clear
//     o_res_valid; if FIFO non-empty pop next -> EXEC, else -> IDLE.
//   - Latency: accept at cycle N into idle block -> o_res_valid high at N+3.
//   - Throughput with i_res_ready=1: one result every 2 cycles (DONE->EXEC->DONE).
//   - Capacity under back-pressure: DEPTH queued + 1 in result register.
//   - o_alu_* keep last issued values in IDLE (no toggling when idle).
//   - Opcode 2'b11 not filtered; ALU flags (incl. err) reported unchanged.
// CONFIGURATION
//   ALU_ISSUER_STATS_EN defined: adds o_cmd_cnt (out, 16) = results delivered and
//     o_err_cnt (out, 16) = delivered results with err flag set; both count on result
//     handshake only, saturate at 16'hFFFF, cleared by i_rst.
//   Not defined: both ports and counters absent; all other behaviour identical.
// TESTING
//   1. i_rst=1 two cycles -> o_cmd_ready=1, o_res_valid=0, o_alu_*=0, o_res*=0.
//   2. push a=10,b=5,op=00 at cycle N, i_res_ready=1 -> o_alu_a=10,o_alu_b=5 at N+2;
//      o_res_valid=1 at N+3 with o_res=5, o_res_op=00, flags equal ALU model; valid drops N+4.
//   3. DEPTH=4, i_res_ready=0, push 6 commands back-to-back -> 5 accepted, then
//      o_cmd_ready=0; first result held stable on o_res for >=10 cycles.
//   4. then i_res_ready=1 -> remaining 4 results appear in push order, one every 2 cycles;
//      o_cmd_ready returns to 1 the cycle after the first pop.
//   5. i_rst pulsed in DONE with 3 queued -> next cycle o_res_valid=0, o_cmd_ready=1; after
//      release no stale result appears; a new command returns correct result at N+3.
//   6. ALU_ISSUER_STATS_EN: 3 commands, stub drives i_alu_err=1 on 2nd only ->
//      o_cmd_cnt=3, o_err_cnt=1; counter preset near max saturates at 16'hFFFF.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU operand/result and result handshake bundle
// slave = issuer side, master = surrounding environment (command source, ALU, result sink).
interface alu_cmd_issuer_if #(
   parameter int BITS = 8
);
   logic            i_cmd_valid;
   logic            o_cmd_ready;
   logic [BITS-1:0] i_cmd_a;
   logic [BITS-1:0] i_cmd_b;
   logic [1:0]      i_cmd_op;
   logic [BITS-1:0] o_alu_a;
   logic [BITS-1:0] o_alu_b;
   logic [1:0]      o_alu_op;
   logic [BITS-1:0] i_alu_out;
   logic            i_alu_carry;
   logic            i_alu_err;
   logic            i_alu_even;
   logic            i_alu_single;
   logic            o_res_valid;
   logic            i_res_ready;
   logic [BITS-1:0] o_res;
   logic [3:0]      o_res_flags;
   logic [1:0]      o_res_op;

   modport slave (
      input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
      input  i_alu_out, i_alu_carry, i_alu_err, i_alu_even, i_alu_single,
      input  i_res_ready,
      output o_cmd_ready, o_alu_a, o_alu_b, o_alu_op,
      output o_res_valid, o_res, o_res_flags, o_res_op
   );

   modport master (
      output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
      output i_alu_out, i_alu_carry, i_alu_err, i_alu_even, i_alu_single,
      output i_res_ready,
      input  o_cmd_ready, o_alu_a, o_alu_b, o_alu_op,
      input  o_res_valid, o_res, o_res_flags, o_res_op
   );
endinterface

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - FIFO-buffered issue stage wrapping a combinational ALU
// Optional delivery/error counters enabled by defining ALU_ISSUER_STATS_EN.
module alu_cmd_issuer #(
   parameter int BITS  = 8,
   parameter int DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   alu_cmd_issuer_if.slave   bus
`ifdef ALU_ISSUER_STATS_EN
   ,
   output logic [15:0]       o_cmd_cnt,
   output logic [15:0]       o_err_cnt
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [BITS-1:0] a;
      logic [BITS-1:0] b;
      logic [1:0]      op;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   cmd_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   state_t        state;
   state_t        state_nx;
   logic          cmd_ready;
   logic          push;
   logic          pop;
   logic          res_hs;
   logic          not_empty;

   // Ready comes from the registered count only, so a full FIFO refuses even while popping.
   assign cmd_ready       = (count != FULL_CNT);
   assign bus.o_cmd_ready = cmd_ready;
   assign push            = bus.i_cmd_valid && cmd_ready;
   assign not_empty       = (count != '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      res_hs   = 1'b0;
      case (state)
         IDLE: begin
            if (not_empty) begin
               pop      = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: state_nx = DONE;
         DONE: begin
            if (bus.i_res_ready) begin
               res_hs = 1'b1;
               if (not_empty) begin
                  pop      = 1'b1;
                  state_nx = EXEC;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= '{a: bus.i_cmd_a, b: bus.i_cmd_b, op: bus.i_cmd_op};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   // Operand and result registers only move on pop/capture, so they hold steady otherwise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bus.o_alu_a     <= '0;
         bus.o_alu_b     <= '0;
         bus.o_alu_op    <= '0;
         bus.o_res       <= '0;
         bus.o_res_flags <= '0;
         bus.o_res_op    <= '0;
         bus.o_res_valid <= 1'b0;
      end else begin
         if (pop) begin
            bus.o_alu_a  <= mem[rd_ptr].a;
            bus.o_alu_b  <= mem[rd_ptr].b;
            bus.o_alu_op <= mem[rd_ptr].op;
         end
         if (state == EXEC) begin
            bus.o_res       <= bus.i_alu_out;
            bus.o_res_flags <= {bus.i_alu_carry, bus.i_alu_err, bus.i_alu_even, bus.i_alu_single};
            bus.o_res_op    <= bus.o_alu_op;
            bus.o_res_valid <= 1'b1;
         end else if (res_hs) begin
            bus.o_res_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ISSUER_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_cmd_cnt <= '0;
         o_err_cnt <= '0;
      end else if (res_hs) begin
         if (o_cmd_cnt != 16'hFFFF) o_cmd_cnt <= o_cmd_cnt + 16'd1;
         if (bus.o_res_flags[2] && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - randomized self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   cmd_t        model_q[$];
   int          dl_cyc[$];
   logic        held = 1'b0;
   logic [31:0] held_val = '0;
   logic [11:0] stub;

   alu_cmd_issuer_if #(.BITS(8)) bus ();

`ifdef ALU_ISSUER_STATS_EN
   logic [15:0] cmd_cnt;
   logic [15:0] err_cnt;
`endif

   alu_cmd_issuer #(.BITS(8), .DEPTH(4)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus)
`ifdef ALU_ISSUER_STATS_EN
      ,
      .o_cmd_cnt(cmd_cnt),
      .o_err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in ALU: returns {carry, err, even, single, out}
   function automatic logic [11:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [1:0] op);
      logic [8:0] w;
      case (op)
         2'b00:   w = {1'b0, a} - {1'b0, b};
         2'b01:   w = {1'b0, a} + {1'b0, b};
         2'b10:   w = {a, 1'b0};
         default: w = {1'b0, a ^ b};
      endcase
      return {w[8], (op == 2'b11), ~w[0], $onehot(w[7:0]), w[7:0]};
   endfunction

   assign stub             = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
   assign bus.i_alu_out    = stub[7:0];
   assign bus.i_alu_single = stub[8];
   assign bus.i_alu_even   = stub[9];
   assign bus.i_alu_err    = stub[10];
   assign bus.i_alu_carry  = stub[11];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observes handshakes of the current cycle against the model, then advances one clock.
   task automatic cycle();
      cmd_t        c;
      logic [11:0] e;
      if (rst) begin
         model_q.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold_valid", {31'b0, bus.o_res_valid}, 32'd1);
            check("hold_stable", {2'b0, bus.o_res_flags, bus.o_res_op, bus.o_res,
                                  bus.o_alu_a, bus.o_alu_b}, held_val);
         end
         if (bus.o_res_valid && bus.i_res_ready) begin
            if (model_q.size() == 0) begin
               check("res_unexpected", {31'b0, bus.o_res_valid}, 32'd0);
            end else begin
               c = model_q.pop_front();
               e = alu_ref(c.a, c.b, c.op);
               check("res", {24'b0, bus.o_res}, {24'b0, e[7:0]});
               check("res_flags", {28'b0, bus.o_res_flags}, {28'b0, e[11:8]});
               check("res_op", {30'b0, bus.o_res_op}, {30'b0, c.op});
            end
            dl_cyc.push_back(cyc);
         end
         if (bus.i_cmd_valid && bus.o_cmd_ready)
            model_q.push_back('{a: bus.i_cmd_a, b: bus.i_cmd_b, op: bus.i_cmd_op});
         held     = bus.o_res_valid && !bus.i_res_ready;
         held_val = {2'b0, bus.o_res_flags, bus.o_res_op, bus.o_res, bus.o_alu_a, bus.o_alu_b};
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_cmd(logic v, logic [7:0] a, logic [7:0] b, logic [1:0] op);
      bus.i_cmd_valid = v;
      bus.i_cmd_a     = a;
      bus.i_cmd_b     = b;
      bus.i_cmd_op    = op;
   endtask

   // Single command into an idle block: operands at N+2, result at N+3, gone at N+4.
   task automatic latency_check(string t, logic [7:0] a, logic [7:0] b, logic [1:0] op);
      logic [11:0] e;
      e = alu_ref(a, b, op);
      bus.i_res_ready = 1'b1;
      check({t, "_ready_n"}, {31'b0, bus.o_cmd_ready}, 32'd1);
      set_cmd(1'b1, a, b, op);
      cycle();
      set_cmd(1'b0, 8'd0, 8'd0, 2'd0);
      check({t, "_valid_n1"}, {31'b0, bus.o_res_valid}, 32'd0);
      cycle();
      check({t, "_alu_a"}, {24'b0, bus.o_alu_a}, {24'b0, a});
      check({t, "_alu_b"}, {24'b0, bus.o_alu_b}, {24'b0, b});
      check({t, "_alu_op"}, {30'b0, bus.o_alu_op}, {30'b0, op});
      check({t, "_valid_n2"}, {31'b0, bus.o_res_valid}, 32'd0);
      cycle();
      check({t, "_valid_n3"}, {31'b0, bus.o_res_valid}, 32'd1);
      check({t, "_res_n3"}, {24'b0, bus.o_res}, {24'b0, e[7:0]});
      check({t, "_flags_n3"}, {28'b0, bus.o_res_flags}, {28'b0, e[11:8]});
      cycle();
      check({t, "_valid_n4"}, {31'b0, bus.o_res_valid}, 32'd0);
   endtask

   initial begin
      int          accepted;
      int          n_before;
      int          k;
      int          seen_valid;
      logic [7:0]  first_res;

      set_cmd(1'b0, 8'd0, 8'd0, 2'd0);
      bus.i_res_ready = 1'b0;
      rst = 1'b1;
      cycle();
      cycle();
      check("rst_cmd_ready", {31'b0, bus.o_cmd_ready}, 32'd1);
      check("rst_res_valid", {31'b0, bus.o_res_valid}, 32'd0);
      check("rst_alu", {14'b0, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}, 32'd0);
      check("rst_res", {18'b0, bus.o_res, bus.o_res_flags, bus.o_res_op}, 32'd0);
      rst = 1'b0;
      cycle();

      latency_check("lat_sub", 8'd10, 8'd5, 2'b00);
      check("lat_sub_value", {24'b0, bus.o_res}, 32'd5);

      // Back-pressure: DEPTH queued plus one in the result register
      bus.i_res_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         set_cmd(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
         if (bus.o_cmd_ready) accepted++;
         cycle();
      end
      set_cmd(1'b0, 8'd0, 8'd0, 2'd0);
      check("bp_accepted", accepted, 32'd5);
      check("bp_ready_low", {31'b0, bus.o_cmd_ready}, 32'd0);
      check("bp_valid", {31'b0, bus.o_res_valid}, 32'd1);
      first_res = bus.o_res;
      for (int i = 0; i < 10; i++) cycle();
      check("bp_res_held", {24'b0, bus.o_res}, {24'b0, first_res});

      // Drain: one result every 2 cycles, ready returns right after the first pop
      bus.i_res_ready = 1'b1;
      dl_cyc.delete();
      for (k = 0; k < 40 && (model_q.size() != 0); k++) begin
         n_before = dl_cyc.size();
         cycle();
         if (n_before == 0 && dl_cyc.size() == 1)
            check("drain_ready_back", {31'b0, bus.o_cmd_ready}, 32'd1);
      end
      check("drain_count", dl_cyc.size(), 32'd5);
      for (int i = 1; i < dl_cyc.size(); i++)
         check("drain_spacing", dl_cyc[i] - dl_cyc[i-1], 32'd2);
      cycle();

      // Reset while DONE with three queued
      bus.i_res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_cmd(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
         cycle();
      end
      set_cmd(1'b0, 8'd0, 8'd0, 2'd0);
      check("mid_valid_before", {31'b0, bus.o_res_valid}, 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mid_rst_valid", {31'b0, bus.o_res_valid}, 32'd0);
      check("mid_rst_ready", {31'b0, bus.o_cmd_ready}, 32'd1);
      bus.i_res_ready = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.o_res_valid) seen_valid++;
         cycle();
      end
      check("mid_no_stale", seen_valid, 32'd0);
      latency_check("lat_after_rst", 8'd200, 8'd100, 2'b00);

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         set_cmd(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
         bus.i_res_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      set_cmd(1'b0, 8'd0, 8'd0, 2'd0);
      bus.i_res_ready = 1'b1;
      for (k = 0; k < 60 && (model_q.size() != 0 || bus.o_res_valid); k++) cycle();
      check("rand_drained", model_q.size(), 32'd0);
      check("rand_idle_valid", {31'b0, bus.o_res_valid}, 32'd0);

`ifdef ALU_ISSUER_STATS_EN
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("stats_rst", {cmd_cnt, err_cnt}, 32'd0);
      latency_check("st1", 8'd3, 8'd1, 2'b00);
      latency_check("st2", 8'd7, 8'd2, 2'b11);
      latency_check("st3", 8'd4, 8'd4, 2'b01);
      check("stats_cmd_cnt", {16'b0, cmd_cnt}, 32'd3);
      check("stats_err_cnt", {16'b0, err_cnt}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
